except_commit: RTL and testbench
================================

EXCEPT_COMMIT -- requirements
Module: except_commit

Interface
REQ-001 SHALL have ports, clock and reset first: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-002 SHALL have commit_valid in 2 (per-slot retire valid, slot0 oldest), commit_except in 2 (per-slot exception flag), commit_ertn in 2 (per-slot ERTN).
REQ-003 SHALL have commit_ecode in 2x6 (Ecode), commit_pc in 2x32 (instruction PC), commit_fault_addr in 2x32 (faulting virtual address).
REQ-004 SHALL have eentry in 32 (general handler base), tlbrentry in 32 (TLB-refill handler base), era in 32 (current ERA CSR), drain_done in 1 (backend drained).
REQ-005 SHALL have except_TLB_addr_en out 1 and except_TLB_addr_PC out 32, driving the BADV capture port.
REQ-006 SHALL have era_wr_en out 1, era_wr_data out 32, estat_wr_en out 1, estat_ecode out 6.
REQ-007 SHALL have flush out 1, commit_stall out 1, redirect_en out 1, redirect_pc out 32.

Function
REQ-008 SHALL implement FSM IDLE -> FLUSH -> DRAIN -> REDIRECT -> IDLE.
REQ-009 In IDLE, SHALL capture the oldest event: slot0 if commit_valid[0] and (except or ertn); else slot1 if commit_valid[1] and (except or ertn) and commit_valid[0]. Capture moves the FSM to FLUSH.
REQ-010 Within one slot, exception SHALL take priority over ertn.
REQ-011 No capture SHALL occur outside IDLE; commit inputs are ignored.
REQ-012 FLUSH lasts exactly 1 cycle; for an exception it pulses era_wr_en (data = captured pc) and estat_wr_en (captured ecode).
REQ-013 In FLUSH, except_TLB_addr_en SHALL pulse for 1 cycle iff the captured ecode is BADV-class (REQ-022), with except_TLB_addr_PC = captured fault address; otherwise both stay 0.
REQ-014 For ertn, FLUSH SHALL write no CSR.
REQ-015 flush SHALL be high in FLUSH and DRAIN; the FSM stays in DRAIN until drain_done=1, with no timeout.
REQ-016 REDIRECT lasts 1 cycle; redirect_en=1 with redirect_pc as follows: ertn -> era sampled in REDIRECT; ecode 0x3F with TLB enabled -> tlbrentry; otherwise eentry.
REQ-017 commit_stall SHALL be high in every state except IDLE.
REQ-018 All outputs SHALL be registered, so capture at cycle N gives CSR pulses in cycle N+1.
REQ-019 Minimum spacing between two events SHALL be 4 cycles: FLUSH, DRAIN with drain_done already high, REDIRECT, IDLE.

Reset
REQ-020 rst SHALL return the FSM to IDLE from any state, including mid-DRAIN, with no redirect issued.
REQ-021 On rst, all outputs and captured registers SHALL be 0.

Configuration
REQ-022 Macro EXCEPT_TLB_EN:
- Defined: BADV-class ecodes are ADEF 0x08, ALE 0x09, PIL 0x01, PIS 0x02, PIF 0x03, PME 0x04, PPI 0x07, TLBR 0x3F; TLBR redirects to tlbrentry.
- Undefined: BADV-class is only 0x08 and 0x09; tlbrentry is unused and all exceptions redirect to eentry.

Structure
REQ-023 Ecode constants, BADV-class list and FSM state encoding SHALL live in shared package csr_pkg.
REQ-024 One sub-module, except_select, SHALL hold the combinational oldest-slot priority of REQ-009/010; FSM and output registers stay in except_commit.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- slot0 exc ecode 0x09, pc 0x1C000100, fault 0x00000203 -> next cycle except_TLB_addr_en=1/PC=0x00000203, era_wr_data=0x1C000100, estat_ecode=0x09; after drain_done, redirect_pc=eentry.
- slot0 normal, slot1 exc ecode 0x0B (SYS) pc 0x1C000204 -> era 0x1C000204 written, except_TLB_addr_en stays 0.
- slot0 ertn, era=0x1C000400 -> no CSR writes, redirect_pc=0x1C000400.
- ecode 0x3F, fault 0x80001000, tlbrentry 0x1C008000 -> with EXCEPT_TLB_EN: BADV pulse and redirect 0x1C008000; without: no BADV pulse and redirect eentry.
- drain_done held 0 for 10 cycles -> flush and commit_stall high throughout; new commits ignored.
- rst asserted in DRAIN -> next cycle all outputs 0, state IDLE, no redirect.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared CSR/exception constants, commit FSM encoding and ecode classification helpers.
// Optional feature macro: EXCEPT_TLB_EN (TLB-related BADV ecodes and TLB-refill redirect).
package csr_pkg;

    localparam logic [5:0] ECODE_PIL  = 6'h01;
    localparam logic [5:0] ECODE_PIS  = 6'h02;
    localparam logic [5:0] ECODE_PIF  = 6'h03;
    localparam logic [5:0] ECODE_PME  = 6'h04;
    localparam logic [5:0] ECODE_PPI  = 6'h07;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_TLBR = 6'h3F;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_REDIRECT = 2'd3
    } commit_state_t;

    // Ecodes whose fault address must be captured into BADV.
    function automatic logic is_badv(input logic [5:0] ecode);
`ifdef EXCEPT_TLB_EN
        case (ecode)
            ECODE_ADEF, ECODE_ALE, ECODE_PIL, ECODE_PIS,
            ECODE_PIF, ECODE_PME, ECODE_PPI, ECODE_TLBR: return 1'b1;
            default:                                     return 1'b0;
        endcase
`else
        return (ecode == ECODE_ADEF) || (ecode == ECODE_ALE);
`endif
    endfunction

    function automatic logic is_tlb_refill(input logic [5:0] ecode);
`ifdef EXCEPT_TLB_EN
        return ecode == ECODE_TLBR;
`else
        return 1'b0;
`endif
    endfunction

endpackage

// File: rtl/except_select.sv
// Combinational oldest-slot event picker for a two-wide retire stage.
// Slot0 is oldest; slot1 only counts when slot0 retires cleanly. Exception beats ERTN.
module except_select
    import csr_pkg::*;
(
    input  logic [1:0]       commit_valid,
    input  logic [1:0]       commit_except,
    input  logic [1:0]       commit_ertn,
    input  logic [1:0][5:0]  commit_ecode,
    input  logic [1:0][31:0] commit_pc,
    input  logic [1:0][31:0] commit_fault_addr,
    output logic             sel_valid,
    output logic             sel_ertn,
    output logic [5:0]       sel_ecode,
    output logic [31:0]      sel_pc,
    output logic [31:0]      sel_fault
);

    logic [1:0] slot_event;
    logic       slot;

    assign slot_event = commit_valid & (commit_except | commit_ertn);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        sel_valid = 1'b0;
        slot      = 1'b0;
        if (slot_event[0]) begin
            sel_valid = 1'b1;
        end else if (slot_event[1] && commit_valid[0]) begin
            sel_valid = 1'b1;
            slot      = 1'b1;
        end
    end

    assign sel_ertn  = sel_valid && !commit_except[slot] && commit_ertn[slot];
    assign sel_ecode = commit_ecode[slot];
    assign sel_pc    = commit_pc[slot];
    assign sel_fault = commit_fault_addr[slot];

endmodule

// File: rtl/except_commit.sv
// Exception/ERTN commit sequencer: IDLE -> FLUSH -> DRAIN -> REDIRECT, all outputs registered.
// Optional feature macro: EXCEPT_TLB_EN (TLB-refill redirect to tlbrentry, wider BADV set).
module except_commit
    import csr_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       commit_valid,
    input  logic [1:0]       commit_except,
    input  logic [1:0]       commit_ertn,
    input  logic [1:0][5:0]  commit_ecode,
    input  logic [1:0][31:0] commit_pc,
    input  logic [1:0][31:0] commit_fault_addr,
    input  logic [31:0]      eentry,
    input  logic [31:0]      tlbrentry,
    input  logic [31:0]      era,
    input  logic             drain_done,
    output logic             except_TLB_addr_en,
    output logic [31:0]      except_TLB_addr_PC,
    output logic             era_wr_en,
    output logic [31:0]      era_wr_data,
    output logic             estat_wr_en,
    output logic [5:0]       estat_ecode,
    output logic             flush,
    output logic             commit_stall,
    output logic             redirect_en,
    output logic [31:0]      redirect_pc
);

    commit_state_t state_q, state_d;

    logic        sel_valid, sel_ertn;
    logic [5:0]  sel_ecode;
    logic [31:0] sel_pc, sel_fault;

    logic        cap_ertn_q, cap_ertn_d;
    logic [5:0]  cap_ecode_q, cap_ecode_d;
    logic [31:0] cap_pc_q, cap_pc_d;
    logic [31:0] cap_fault_q, cap_fault_d;

    logic        badv_en_q, badv_en_d;
    logic [31:0] badv_pc_q, badv_pc_d;
    logic        era_wr_en_q, era_wr_en_d;
    logic [31:0] era_wr_data_q, era_wr_data_d;
    logic        estat_wr_en_q, estat_wr_en_d;
    logic [5:0]  estat_ecode_q, estat_ecode_d;
    logic        flush_q, flush_d;
    logic        stall_q, stall_d;
    logic        redirect_en_q, redirect_en_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic [31:0] handler_pc;

    except_select u_select (
        .commit_valid      (commit_valid),
        .commit_except     (commit_except),
        .commit_ertn       (commit_ertn),
        .commit_ecode      (commit_ecode),
        .commit_pc         (commit_pc),
        .commit_fault_addr (commit_fault_addr),
        .sel_valid         (sel_valid),
        .sel_ertn          (sel_ertn),
        .sel_ecode         (sel_ecode),
        .sel_pc            (sel_pc),
        .sel_fault         (sel_fault)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cap_ertn_q    <= 1'b0;
            cap_ecode_q   <= '0;
            cap_pc_q      <= '0;
            cap_fault_q   <= '0;
            badv_en_q     <= 1'b0;
            badv_pc_q     <= '0;
            era_wr_en_q   <= 1'b0;
            era_wr_data_q <= '0;
            estat_wr_en_q <= 1'b0;
            estat_ecode_q <= '0;
            flush_q       <= 1'b0;
            stall_q       <= 1'b0;
            redirect_en_q <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            cap_ertn_q    <= cap_ertn_d;
            cap_ecode_q   <= cap_ecode_d;
            cap_pc_q      <= cap_pc_d;
            cap_fault_q   <= cap_fault_d;
            badv_en_q     <= badv_en_d;
            badv_pc_q     <= badv_pc_d;
            era_wr_en_q   <= era_wr_en_d;
            era_wr_data_q <= era_wr_data_d;
            estat_wr_en_q <= estat_wr_en_d;
            estat_ecode_q <= estat_ecode_d;
            flush_q       <= flush_d;
            stall_q       <= stall_d;
            redirect_en_q <= redirect_en_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    // Next state and event capture; commit inputs only matter while idle.
    always_comb begin
        state_d     = state_q;
        cap_ertn_d  = cap_ertn_q;
        cap_ecode_d = cap_ecode_q;
        cap_pc_d    = cap_pc_q;
        cap_fault_d = cap_fault_q;
        unique case (state_q)
            ST_IDLE: begin
                if (sel_valid) begin
                    state_d     = ST_FLUSH;
                    cap_ertn_d  = sel_ertn;
                    cap_ecode_d = sel_ecode;
                    cap_pc_d    = sel_pc;
                    cap_fault_d = sel_fault;
                end
            end
            ST_FLUSH:    state_d = ST_DRAIN;
            ST_DRAIN:    if (drain_done) state_d = ST_REDIRECT;
            ST_REDIRECT: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

`ifdef EXCEPT_TLB_EN
    assign handler_pc = is_tlb_refill(cap_ecode_d) ? tlbrentry : eentry;
`else
    logic unused_tlbrentry;
    assign unused_tlbrentry = ^tlbrentry;
    assign handler_pc       = eentry;
`endif

    // Outputs are decoded from the upcoming state so they appear registered in that state.
    always_comb begin
        badv_en_d     = (state_d == ST_FLUSH) && !cap_ertn_d && is_badv(cap_ecode_d);
        badv_pc_d     = badv_en_d ? cap_fault_d : '0;
        era_wr_en_d   = (state_d == ST_FLUSH) && !cap_ertn_d;
        era_wr_data_d = era_wr_en_d ? cap_pc_d : '0;
        estat_wr_en_d = era_wr_en_d;
        estat_ecode_d = era_wr_en_d ? cap_ecode_d : '0;
        flush_d       = (state_d == ST_FLUSH) || (state_d == ST_DRAIN);
        stall_d       = (state_d != ST_IDLE);
        redirect_en_d = (state_d == ST_REDIRECT);
        redirect_pc_d = '0;
        if (redirect_en_d) begin
            redirect_pc_d = cap_ertn_d ? era : handler_pc;
        end
    end

    assign except_TLB_addr_en = badv_en_q;
    assign except_TLB_addr_PC = badv_pc_q;
    assign era_wr_en          = era_wr_en_q;
    assign era_wr_data        = era_wr_data_q;
    assign estat_wr_en        = estat_wr_en_q;
    assign estat_ecode        = estat_ecode_q;
    assign flush              = flush_q;
    assign commit_stall       = stall_q;
    assign redirect_en        = redirect_en_q;
    assign redirect_pc        = redirect_pc_q;

endmodule

// File: tb/tb_except_commit.sv
// Directed bench for except_commit; expectations are hand-derived per scenario.
// Build with +define+EXCEPT_TLB_EN to exercise the TLB-enabled expectations.
module tb_except_commit;

    logic             clk;
    logic             rst;
    logic [1:0]       commit_valid;
    logic [1:0]       commit_except;
    logic [1:0]       commit_ertn;
    logic [1:0][5:0]  commit_ecode;
    logic [1:0][31:0] commit_pc;
    logic [1:0][31:0] commit_fault_addr;
    logic [31:0]      eentry;
    logic [31:0]      tlbrentry;
    logic [31:0]      era;
    logic             drain_done;
    logic             except_TLB_addr_en;
    logic [31:0]      except_TLB_addr_PC;
    logic             era_wr_en;
    logic [31:0]      era_wr_data;
    logic             estat_wr_en;
    logic [5:0]       estat_ecode;
    logic             flush;
    logic             commit_stall;
    logic             redirect_en;
    logic [31:0]      redirect_pc;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] EENTRY    = 32'h1C00_1000;
    localparam logic [31:0] TLBRENTRY = 32'h1C00_8000;
`ifdef EXCEPT_TLB_EN
    localparam bit TLB_ON = 1'b1;
`else
    localparam bit TLB_ON = 1'b0;
`endif

    except_commit dut (
        .clk                (clk),
        .rst                (rst),
        .commit_valid       (commit_valid),
        .commit_except      (commit_except),
        .commit_ertn        (commit_ertn),
        .commit_ecode       (commit_ecode),
        .commit_pc          (commit_pc),
        .commit_fault_addr  (commit_fault_addr),
        .eentry             (eentry),
        .tlbrentry          (tlbrentry),
        .era                (era),
        .drain_done         (drain_done),
        .except_TLB_addr_en (except_TLB_addr_en),
        .except_TLB_addr_PC (except_TLB_addr_PC),
        .era_wr_en          (era_wr_en),
        .era_wr_data        (era_wr_data),
        .estat_wr_en        (estat_wr_en),
        .estat_ecode        (estat_ecode),
        .flush              (flush),
        .commit_stall       (commit_stall),
        .redirect_en        (redirect_en),
        .redirect_pc        (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_commit();
        commit_valid      = '0;
        commit_except     = '0;
        commit_ertn       = '0;
        commit_ecode      = '0;
        commit_pc         = '0;
        commit_fault_addr = '0;
    endtask

    task automatic slot_event(input int s, input bit exc, input bit ertn_f,
                              input logic [5:0] ec, input logic [31:0] pc,
                              input logic [31:0] fa);
        commit_valid[s]      = 1'b1;
        commit_except[s]     = exc;
        commit_ertn[s]       = ertn_f;
        commit_ecode[s]      = ec;
        commit_pc[s]         = pc;
        commit_fault_addr[s] = fa;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".badv_en"},  32'(except_TLB_addr_en), 32'd0);
        check({tag, ".badv_pc"},  except_TLB_addr_PC,      32'd0);
        check({tag, ".era_en"},   32'(era_wr_en),          32'd0);
        check({tag, ".era_data"}, era_wr_data,             32'd0);
        check({tag, ".estat_en"}, 32'(estat_wr_en),        32'd0);
        check({tag, ".ecode"},    32'(estat_ecode),        32'd0);
        check({tag, ".flush"},    32'(flush),              32'd0);
        check({tag, ".stall"},    32'(commit_stall),       32'd0);
        check({tag, ".redir_en"}, 32'(redirect_en),        32'd0);
        check({tag, ".redir_pc"}, redirect_pc,             32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        eentry     = EENTRY;
        tlbrentry  = TLBRENTRY;
        era        = 32'h1C00_0400;
        drain_done = 1'b0;
        clear_commit();

        // Reset state
        step();
        step();
        check_all_zero("reset");
        rst = 1'b0;
        step();
        check_all_zero("post_reset_idle");

        // Slot1 event with slot0 not retiring is not an oldest event
        slot_event(1, 1'b1, 1'b0, 6'h0B, 32'h1C00_0050, 32'h0);
        commit_valid[0] = 1'b0;
        step();
        check("slot1_alone.stall", 32'(commit_stall), 32'd0);
        clear_commit();

        // Scenario 1: slot0 ALE
        slot_event(0, 1'b1, 1'b0, 6'h09, 32'h1C00_0100, 32'h0000_0203);
        step();
        clear_commit();
        check("s1.badv_en",   32'(except_TLB_addr_en), 32'd1);
        check("s1.badv_pc",   except_TLB_addr_PC,      32'h0000_0203);
        check("s1.era_en",    32'(era_wr_en),          32'd1);
        check("s1.era_data",  era_wr_data,             32'h1C00_0100);
        check("s1.estat_en",  32'(estat_wr_en),        32'd1);
        check("s1.ecode",     32'(estat_ecode),        32'h09);
        check("s1.flush",     32'(flush),              32'd1);
        check("s1.stall",     32'(commit_stall),       32'd1);
        step();
        check("s1.drain.badv_en", 32'(except_TLB_addr_en), 32'd0);
        check("s1.drain.era_en",  32'(era_wr_en),          32'd0);
        check("s1.drain.flush",   32'(flush),              32'd1);
        check("s1.drain.redir",   32'(redirect_en),        32'd0);
        drain_done = 1'b1;
        step();
        check("s1.redir_en",  32'(redirect_en),  32'd1);
        check("s1.redir_pc",  redirect_pc,       EENTRY);
        check("s1.redir.flush", 32'(flush),      32'd0);
        check("s1.redir.stall", 32'(commit_stall), 32'd1);
        step();
        check("s1.idle.redir", 32'(redirect_en),  32'd0);
        check("s1.idle.stall", 32'(commit_stall), 32'd0);

        // Scenario 2: slot0 normal, slot1 SYS; drain_done already high -> 4-cycle spacing
        commit_valid[0] = 1'b1;
        slot_event(1, 1'b1, 1'b0, 6'h0B, 32'h1C00_0204, 32'hDEAD_0000);
        step();
        clear_commit();
        check("s2.era_en",   32'(era_wr_en),          32'd1);
        check("s2.era_data", era_wr_data,             32'h1C00_0204);
        check("s2.ecode",    32'(estat_ecode),        32'h0B);
        check("s2.badv_en",  32'(except_TLB_addr_en), 32'd0);
        step();
        check("s2.drain.flush", 32'(flush), 32'd1);
        step();
        check("s2.redir_pc", redirect_pc, EENTRY);
        step();
        check("s2.idle.stall", 32'(commit_stall), 32'd0);

        // Scenario 3: slot0 ERTN returns to ERA, no CSR writes
        era = 32'h1C00_0400;
        slot_event(0, 1'b0, 1'b1, 6'h00, 32'h1C00_0300, 32'h0);
        step();
        clear_commit();
        check("s3.era_en",   32'(era_wr_en),          32'd0);
        check("s3.estat_en", 32'(estat_wr_en),        32'd0);
        check("s3.badv_en",  32'(except_TLB_addr_en), 32'd0);
        check("s3.flush",    32'(flush),              32'd1);
        step();
        step();
        check("s3.redir_en", 32'(redirect_en), 32'd1);
        check("s3.redir_pc", redirect_pc,      32'h1C00_0400);
        step();

        // Scenario 4: TLB refill
        slot_event(0, 1'b1, 1'b0, 6'h3F, 32'h1C00_0500, 32'h8000_1000);
        step();
        clear_commit();
        check("s4.badv_en", 32'(except_TLB_addr_en), 32'(TLB_ON));
        check("s4.badv_pc", except_TLB_addr_PC,      TLB_ON ? 32'h8000_1000 : 32'h0);
        check("s4.ecode",   32'(estat_ecode),        32'h3F);
        step();
        step();
        check("s4.redir_pc", redirect_pc, TLB_ON ? TLBRENTRY : EENTRY);
        step();

        // Scenario 5: PIL with a long drain; commits during drain are ignored
        drain_done = 1'b0;
        slot_event(0, 1'b1, 1'b0, 6'h01, 32'h1C00_0600, 32'h0000_0777);
        step();
        check("s5.badv_en", 32'(except_TLB_addr_en), 32'(TLB_ON));
        check("s5.era_data", era_wr_data, 32'h1C00_0600);
        clear_commit();
        slot_event(0, 1'b1, 1'b0, 6'h08, 32'h1C00_0700, 32'h0000_0888);
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("s5.hold%0d.flush", i), 32'(flush),        32'd1);
            check($sformatf("s5.hold%0d.stall", i), 32'(commit_stall), 32'd1);
            check($sformatf("s5.hold%0d.era",   i), 32'(era_wr_en),    32'd0);
            check($sformatf("s5.hold%0d.redir", i), 32'(redirect_en),  32'd0);
        end
        clear_commit();
        drain_done = 1'b1;
        step();
        check("s5.redir_en", 32'(redirect_en), 32'd1);
        check("s5.redir_pc", redirect_pc,      EENTRY);
        step();
        check("s5.idle.era", 32'(era_wr_en), 32'd0);

        // Scenario 6: exception beats ERTN in one slot, then reset mid-DRAIN
        drain_done = 1'b0;
        slot_event(0, 1'b1, 1'b1, 6'h0B, 32'h1C00_0900, 32'h0);
        step();
        clear_commit();
        check("s6.prio.era_en",   32'(era_wr_en), 32'd1);
        check("s6.prio.era_data", era_wr_data,    32'h1C00_0900);
        step();
        step();
        check("s6.drain.flush", 32'(flush), 32'd1);
        rst = 1'b1;
        step();
        check_all_zero("s6.rst");
        rst        = 1'b0;
        drain_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("s6.after%0d.redir", i), 32'(redirect_en),  32'd0);
            check($sformatf("s6.after%0d.stall", i), 32'(commit_stall), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
